// File: rtl/vx_cache_pkg.sv
// Shared constants, line/dirty types and request-op decoding for the cache bank data store.
package vx_cache_pkg;

    function automatic int clog2Min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int CFG_CACHE_SIZE      = 16384;
    localparam int CFG_CACHE_LINE_SIZE = 64;
    localparam int CFG_NUM_BANKS       = 1;
    localparam int CFG_NUM_WAYS        = 4;
    localparam int CFG_NUM_PORTS       = 1;
    localparam int CFG_WORD_SIZE       = 4;
    localparam int CFG_LINE_ADDR_WIDTH = 26;

    localparam int LINES_PER_WAY  = CFG_CACHE_SIZE / (CFG_CACHE_LINE_SIZE * CFG_NUM_BANKS * CFG_NUM_WAYS);
    localparam int WORDS_PER_LINE = CFG_CACHE_LINE_SIZE / CFG_WORD_SIZE;
    localparam int WAY_SEL_BITS   = clog2Min1(CFG_NUM_WAYS);
    localparam int WORD_SEL_BITS  = clog2Min1(WORDS_PER_LINE);
    localparam int LINE_SEL_BITS  = clog2Min1(LINES_PER_WAY);

    typedef logic [CFG_CACHE_LINE_SIZE*8-1:0] line_t;
    typedef logic [CFG_CACHE_LINE_SIZE-1:0]   dirty_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_READ,
        OP_WRITE,
        OP_FILL,
        OP_FLUSH
    } op_e;

    // Requests should be one-hot; when they are not, fill > flush > write > read.
    function automatic op_e decodeOp(input logic rd, input logic wr, input logic fl, input logic fs);
        if (fl)      return OP_FILL;
        else if (fs) return OP_FLUSH;
        else if (wr) return OP_WRITE;
        else if (rd) return OP_READ;
        else         return OP_NONE;
    endfunction

endpackage

// File: rtl/vx_data_way.sv
// One way of the bank data store: read-first line RAM with byte enables, per-byte dirty
// mask array and the port-merging write-mask builder.
module vx_data_way
    import vx_cache_pkg::*;
#(
    parameter int LINES        = 64,
    parameter int WORDS        = 16,
    parameter int WORD_SIZE    = 4,
    parameter int NUM_PORTS    = 1,
    parameter int WRITE_ENABLE = 1,
    parameter int WRITEBACK    = 1,
    localparam int IDX_BITS    = clog2Min1(LINES),
    localparam int WSEL_BITS   = clog2Min1(WORDS),
    localparam int LINE_BYTES  = WORDS * WORD_SIZE,
    localparam int LINE_BITS   = LINE_BYTES * 8
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              en_i,
    input  op_e                               op_i,
    input  logic [IDX_BITS-1:0]               index_i,
    input  logic [NUM_PORTS*WSEL_BITS-1:0]    wsel_i,
    input  logic [NUM_PORTS-1:0]              pmask_i,
    input  logic [NUM_PORTS*WORD_SIZE-1:0]    byteen_i,
    input  logic [NUM_PORTS*WORD_SIZE*8-1:0]  write_data_i,
    input  logic [LINE_BITS-1:0]              fill_data_i,
    output logic [LINE_BITS-1:0]              rd_line_o,
    output logic [LINE_BYTES-1:0]             rd_dirty_o
);

    logic [LINE_BITS-1:0]                 mem [LINES];
    logic [WORDS-1:0][WORD_SIZE-1:0]      wordMask;
    logic [WORDS-1:0][WORD_SIZE*8-1:0]    wordData;
    logic [WSEL_BITS-1:0]                 portSel;
    logic [LINE_BYTES-1:0]                wrMask;
    logic [LINE_BITS-1:0]                 wrData;
    logic [LINE_BITS-1:0]                 rdLine_q;

    // Later ports overwrite earlier ones, so a collision keeps the highest port's data and byteen.
    always_comb begin
        wordMask = '0;
        wordData = '0;
        portSel  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (pmask_i[p]) begin
                portSel = (WORDS > 1) ? wsel_i[p*WSEL_BITS +: WSEL_BITS] : '0;
                wordMask[portSel] = byteen_i[p*WORD_SIZE +: WORD_SIZE];
                wordData[portSel] = write_data_i[p*WORD_SIZE*8 +: WORD_SIZE*8];
            end
        end
        wrMask = '0;
        wrData = fill_data_i;
        if (op_i == OP_FILL) begin
            wrMask = '1;
        end else if (op_i == OP_WRITE && WRITE_ENABLE != 0) begin
            wrMask = wordMask;
            wrData = wordData;
        end
    end

    generate
        if (WRITE_ENABLE != 0) begin : g_byteWrite
            always_ff @(posedge clk_i) begin
                if (en_i) begin
                    for (int b = 0; b < LINE_BYTES; b++) begin
                        if (wrMask[b]) mem[index_i][b*8 +: 8] <= wrData[b*8 +: 8];
                    end
                end
            end
        end else begin : g_lineWrite
            always_ff @(posedge clk_i) begin
                if (en_i && op_i == OP_FILL) mem[index_i] <= fill_data_i;
            end
        end
    endgenerate

    // Read-first: the registered line is the content before this edge's write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdLine_q <= '0;
        end else if (en_i) begin
            rdLine_q <= mem[index_i];
        end
    end

    assign rd_line_o = rdLine_q;

    generate
        if (WRITEBACK != 0) begin : g_dirty
            logic [LINE_BYTES-1:0] dirty_q [LINES];
            logic [LINE_BYTES-1:0] rdDirty_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int l = 0; l < LINES; l++) dirty_q[l] <= '0;
                    rdDirty_q <= '0;
                end else if (en_i) begin
                    rdDirty_q <= dirty_q[index_i];
                    case (op_i)
                        OP_FILL, OP_FLUSH: dirty_q[index_i] <= '0;
                        OP_WRITE:          dirty_q[index_i] <= dirty_q[index_i] | wrMask;
                        default:           ;
                    endcase
                end
            end

            assign rd_dirty_o = rdDirty_q;
        end else begin : g_noDirty
            assign rd_dirty_o = '0;
        end
    endgenerate

endmodule

// File: rtl/vx_data_access_assoc.sv
// Set-associative bank data store: decodes the request, enables the selected way and
// muxes the registered way outputs into read and writeback-eviction responses.
module vx_data_access_assoc
    import vx_cache_pkg::*;
#(
    parameter int CACHE_SIZE      = CFG_CACHE_SIZE,
    parameter int CACHE_LINE_SIZE = CFG_CACHE_LINE_SIZE,
    parameter int NUM_BANKS       = CFG_NUM_BANKS,
    parameter int NUM_WAYS        = CFG_NUM_WAYS,
    parameter int NUM_PORTS       = CFG_NUM_PORTS,
    parameter int WORD_SIZE       = CFG_WORD_SIZE,
    parameter int WRITE_ENABLE    = 1,
    parameter int WRITEBACK       = 1,
    parameter int LINE_ADDR_WIDTH = CFG_LINE_ADDR_WIDTH,
    localparam int LINES          = CACHE_SIZE / (CACHE_LINE_SIZE * NUM_BANKS * NUM_WAYS),
    localparam int WORDS          = CACHE_LINE_SIZE / WORD_SIZE,
    localparam int WAY_BITS       = clog2Min1(NUM_WAYS),
    localparam int WSEL_BITS      = clog2Min1(WORDS),
    localparam int IDX_BITS       = clog2Min1(LINES),
    localparam int WORD_BITS      = WORD_SIZE * 8
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              stall_i,
    input  logic                              read_i,
    input  logic                              write_i,
    input  logic                              fill_i,
    input  logic                              flush_i,
    input  logic [WAY_BITS-1:0]               way_sel_i,
    input  logic [LINE_ADDR_WIDTH-1:0]        addr_i,
    input  logic [NUM_PORTS*WSEL_BITS-1:0]    wsel_i,
    input  logic [NUM_PORTS-1:0]              pmask_i,
    input  logic [NUM_PORTS*WORD_SIZE-1:0]    byteen_i,
    input  logic [NUM_PORTS*WORD_BITS-1:0]    write_data_i,
    input  logic [CACHE_LINE_SIZE*8-1:0]      fill_data_i,
    output logic                              read_valid_o,
    output logic [NUM_PORTS*WORD_BITS-1:0]    read_data_o,
    output logic                              evict_valid_o,
    output logic [LINE_ADDR_WIDTH-1:0]        evict_addr_o,
    output logic [CACHE_LINE_SIZE*8-1:0]      evict_data_o,
    output logic [CACHE_LINE_SIZE-1:0]        evict_dirty_o
);

    op_e                             op;
    logic [CACHE_LINE_SIZE*8-1:0]    wayLine  [NUM_WAYS];
    logic [CACHE_LINE_SIZE-1:0]      wayDirty [NUM_WAYS];
    logic [CACHE_LINE_SIZE*8-1:0]    selLine;
    logic [CACHE_LINE_SIZE-1:0]      selDirty;
    logic                            readValid_d, readValid_q;
    logic                            evictOp_d, evictOp_q;
    logic                            evictValid;
    logic [WAY_BITS-1:0]             way_q;
    logic [NUM_PORTS*WSEL_BITS-1:0]  wsel_q;
    logic [LINE_ADDR_WIDTH-1:0]      evictAddr_q;

    function automatic int wordOffset(input logic [WSEL_BITS-1:0] s);
        return (WORDS == 1) ? 0 : int'(s) * WORD_BITS;
    endfunction

    assign op          = stall_i ? OP_NONE : decodeOp(read_i, write_i, fill_i, flush_i);
    assign readValid_d = (op == OP_READ);
    assign evictOp_d   = (WRITEBACK != 0) && (op == OP_FILL || op == OP_FLUSH);

    generate
        for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
            vx_data_way #(
                .LINES        (LINES),
                .WORDS        (WORDS),
                .WORD_SIZE    (WORD_SIZE),
                .NUM_PORTS    (NUM_PORTS),
                .WRITE_ENABLE (WRITE_ENABLE),
                .WRITEBACK    (WRITEBACK)
            ) u_way (
                .clk_i        (clk_i),
                .rst_ni       (rst_ni),
                .en_i         (op != OP_NONE && way_sel_i == WAY_BITS'(w)),
                .op_i         (op),
                .index_i      (addr_i[IDX_BITS-1:0]),
                .wsel_i       (wsel_i),
                .pmask_i      (pmask_i),
                .byteen_i     (byteen_i),
                .write_data_i (write_data_i),
                .fill_data_i  (fill_data_i),
                .rd_line_o    (wayLine[w]),
                .rd_dirty_o   (wayDirty[w])
            );
        end
    endgenerate

    // Capture registers only move on accepted edges, so a stall holds every output stable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            readValid_q <= 1'b0;
            evictOp_q   <= 1'b0;
            way_q       <= '0;
            wsel_q      <= '0;
            evictAddr_q <= '0;
        end else if (!stall_i) begin
            readValid_q <= readValid_d;
            evictOp_q   <= evictOp_d;
            if (op != OP_NONE) way_q       <= way_sel_i;
            if (readValid_d)   wsel_q      <= wsel_i;
            if (evictOp_d)     evictAddr_q <= addr_i;
        end
    end

    assign selLine    = wayLine[way_q];
    assign selDirty   = wayDirty[way_q];
    assign evictValid = evictOp_q && (|selDirty);

    always_comb begin
        read_data_o = '0;
        if (readValid_q) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                read_data_o[p*WORD_BITS +: WORD_BITS] =
                    selLine[wordOffset(wsel_q[p*WSEL_BITS +: WSEL_BITS]) +: WORD_BITS];
            end
        end
    end

    assign read_valid_o  = readValid_q;
    assign evict_valid_o = evictValid;
    assign evict_addr_o  = evictValid ? evictAddr_q : '0;
    assign evict_data_o  = evictValid ? selLine : '0;
    assign evict_dirty_o = evictValid ? selDirty : '0;

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !stall_i |-> $onehot0({read_i, write_i, fill_i, flush_i}))
        else $error("multiple request types asserted in one cycle");

endmodule

// File: doc/vx_data_access_assoc.md
Name: vx_data_access_assoc

Overview:
Set-associative, multi-port data store for one cache bank. It adds several capabilities to the single-way bank data store:
- NUM_WAYS ways
- registered 1-cycle read with a valid flag
- per-byte dirty tracking
- writeback eviction output on fill or flush

It sits in the bank pipeline after tag access, which supplies way_sel. Its evict outputs feed the bank's memory-request queue.

Parameters:
- CACHE_SIZE, 16384, bank-group cache bytes.
- CACHE_LINE_SIZE, 64, line bytes.
- NUM_BANKS, 1, bank count.
- NUM_WAYS, 4, associativity (power of 2, ≥1).
- NUM_PORTS, 1, request ports per bank.
- WORD_SIZE, 4, word bytes.
- WRITE_ENABLE, 1, enables write path.
- WRITEBACK, 1, enables dirty tracking and evict outputs. Requires WRITE_ENABLE.
- Derived: LINES_PER_WAY = CACHE_SIZE/(CACHE_LINE_SIZE·NUM_BANKS·NUM_WAYS); WORDS_PER_LINE = CACHE_LINE_SIZE/WORD_SIZE; WAY_SEL_BITS = UP(log2 NUM_WAYS); WORD_SEL_BITS = UP(log2 WORDS_PER_LINE).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  pipeline stall; freezes all state and outputs.
- read  in  1  read request.
- write  in  1  word write request.
- fill  in  1  whole-line fill request.
- flush  in  1  writeback-and-clean request.
- way_sel  in  WAY_SEL_BITS  target way.
- addr  in  LINE_ADDR_WIDTH  line address; index = addr[log2 LINES_PER_WAY-1:0].
- wsel  in  NUM_PORTS×WORD_SEL_BITS  word select per port.
- pmask  in  NUM_PORTS  port active mask.
- byteen  in  NUM_PORTS×WORD_SIZE  byte enables per port.
- write_data  in  NUM_PORTS×WORD_SIZE·8  write words.
- fill_data  in  CACHE_LINE_SIZE·8  fill line.
- read_valid  out  1  read_data valid.
- read_data  out  NUM_PORTS×WORD_SIZE·8  read words.
- evict_valid  out  1  dirty victim line present.
- evict_addr  out  LINE_ADDR_WIDTH  victim line address (request addr).
- evict_data  out  CACHE_LINE_SIZE·8  victim line data.
- evict_dirty  out  CACHE_LINE_SIZE  victim dirty byte mask.

Behaviour:
- Request acceptance:
  - A request is accepted at a rising edge when ~stall.
  - read/write/fill/flush are one-hot. If several are asserted, priority is fill > flush > write > read; a simulation assertion fires.
- Storage:
  - One sync single-port RAM per way, read-first (old data returned on a write edge), per-byte write enable.
  - Only way way_sel is enabled; other ways are untouched.
- Write:
  - Each active port (pmask[i]) writes byteen[i] bytes of write_data[i] into word wsel[i].
  - Port collision on the same wsel: the highest port index wins for both data and byteen.
  - With WRITEBACK, the written bytes OR into dirty[way][index]. A write with byteen=0 or pmask=0 changes nothing.
- Fill: writes the full line; dirty[way][index] := 0.
- Read:
  - Latency 1: read_valid=1 the cycle after an accepted read.
  - read_data[i] = word wsel[i] (captured) of way way_sel (captured).
  - With WORDS_PER_LINE=1, wsel is ignored.
- Eviction (WRITEBACK only):
  - Triggered by an accepted fill or flush whose old dirty mask ≠ 0.
  - Next cycle: evict_valid=1, evict_addr=addr, evict_data=old line (read-first), evict_dirty=old mask.
  - Flush does not modify line data; it clears dirty.
  - Fill/flush of a clean line gives evict_valid=0.
- Stall:
  - No RAM write, no dirty update.
  - All outputs and the capture registers hold their values. read_valid/evict_valid keep their value, so downstream sees a stable pulse extended across the stall.
- Back-to-back operation:
  - A read the cycle after a write to the same line/way returns the new data (RAM write completes at the prior edge).
  - A fill immediately after a write to the same line evicts the written data.
- WRITEBACK=0: evict_* tied 0 and dirty storage is removed; flush is a no-op.
- WRITE_ENABLE=0: write is ignored, RAM byte width is 1, and only fill writes.
- Reset (asserted low, asynchronous, including mid-operation):
  - read_valid=0, evict_valid=0, read_data=0, evict_data=0, evict_addr=0, evict_dirty=0.
  - All dirty bits clear immediately.
  - RAM contents are undefined.
  - The first edge after deassertion accepts requests normally.

Decomposition:
- Shared package vx_cache_pkg holds:
  - derived constants LINES_PER_WAY, WORDS_PER_LINE, WAY_SEL_BITS, WORD_SEL_BITS, LINE_SEL_BITS;
  - typedefs line_t and dirty_t;
  - an op-encoding enum (NONE/READ/WRITE/FILL/FLUSH) used by the priority decoder.
- Sub-module vx_data_way covers one way: RAM, dirty array, write-mask builder. It is instantiated NUM_WAYS times.
- The top level holds way decode, output muxing and the capture/evict registers.

Test Plan:
- Write then read (NUM_PORTS=2, NUM_WAYS=4):
  - Stimulus: fill way 2, index 5 with 0; write port0 wsel=3 data=DEADBEEF byteen=1111, port1 wsel=7 data=12345678 byteen=0011; read next cycle.
  - Expected: read_valid=1 one cycle later; read_data[0]=DEADBEEF; read_data[1]=00005678.
- Dirty eviction:
  - Stimulus: after the above, fill way 2, index 5.
  - Expected: next cycle evict_valid=1; evict_dirty has bits 12-15 and 28-29 set; evict_data word3=DEADBEEF; new line readable afterwards.
- Flush and clean fill:
  - Stimulus: flush a dirty line, then flush again, then fill a clean line.
  - Expected: the first flush evicts; the second flush and the clean fill give evict_valid=0; line data is unchanged after the flush.
- Stall hold:
  - Stimulus: read, then stall=1 for 3 cycles with write asserted.
  - Expected: read_valid/read_data are held for 3 cycles; the stalled write has no effect on a later read.
- Reset mid-operation:
  - Stimulus: drive reset low asynchronously while evict_valid=1 and dirty lines exist.
  - Expected: outputs go 0 immediately; after release, a fill of a previously dirty line gives evict_valid=0.
- Port collision:
  - Stimulus: ports 0 and 1 both wsel=0; port0 data=AAAAAAAA, port1 data=BBBBBBBB byteen=1100.
  - Expected: stored word = BBBB0000, and dirty covers bytes 2-3 only.
